// File: rtl/spi_tx_framer_pkg.sv
// Shared widths and FSM state encoding for the SPI transmit framer.
package spi_tx_framer_pkg;

  localparam int SPI_BYTE_B = 8;
  localparam int SPI_WORD_B = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_REQ
  } spi_tx_state_e;

endpackage

// File: rtl/spi_tx_holding_reg.sv
// One-entry word buffer between the core and the framer; drops words that
// arrive while full and remembers that it did so until reset.
module spi_tx_holding_reg
  import spi_tx_framer_pkg::*;
#(
  parameter int WORD_B = SPI_WORD_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [WORD_B-1:0] wr_data,
  input  logic              drain,
  output logic              valid,
  output logic              ready,
  output logic [WORD_B-1:0] data,
  output logic              overflow
);

  logic accept;
  logic valid_next;

  // A write in the draining cycle refills the slot rather than being dropped.
  assign accept = wr && (!valid || drain);

  always_comb begin
    valid_next = valid;
    if (drain)  valid_next = 1'b0;
    if (accept) valid_next = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      ready    <= 1'b1;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      valid <= valid_next;
      ready <= ~valid_next;
      if (accept)       data     <= wr_data;
      if (wr && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_tx_framer.sv
// Serializes 64-bit core words into MSB-first bytes for the SPI slave shifter,
// one byte per slave request, with abort on chip-select release.
module spi_tx_framer
  import spi_tx_framer_pkg::*;
#(
  parameter int                WORD_B    = SPI_WORD_B,
  parameter int                BYTE_B    = SPI_BYTE_B,
  parameter logic [BYTE_B-1:0] IDLE_BYTE = '0
) (
  input  logic              CLK100MHZ,
  input  logic              ck_rst,
  input  logic              tx_dv,
  input  logic [WORD_B-1:0] tx_64bit,
  output logic              tx_ready,
  input  logic              spi_byte_req,
  input  logic              spi_cs_n,
  output logic              tran_dv,
  output logic [BYTE_B-1:0] tran_byte,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              overflow
);

  localparam int BYTES = WORD_B / BYTE_B;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  spi_tx_state_e     state, state_next;
  logic              hold_valid;
  logic [WORD_B-1:0] hold_data;
  logic [WORD_B-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  byte_cnt, cnt_next;
  logic              tran_dv_next, done_next, abort_next;
  logic [BYTE_B-1:0] tran_byte_next;
  logic              cs_q;
  logic              cs_rise;

  spi_tx_holding_reg #(.WORD_B(WORD_B)) u_hold (
    .clk      (CLK100MHZ),
    .rst      (ck_rst),
    .wr       (tx_dv),
    .wr_data  (tx_64bit),
    .drain    (state == LOAD),
    .valid    (hold_valid),
    .ready    (tx_ready),
    .data     (hold_data),
    .overflow (overflow)
  );

  assign cs_rise = spi_cs_n && !cs_q;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    cnt_next       = byte_cnt;
    tran_dv_next   = 1'b0;
    tran_byte_next = tran_byte;
    done_next      = 1'b0;
    abort_next     = 1'b0;
    case (state)
      IDLE: begin
        if (hold_valid) state_next = LOAD;
      end
      LOAD: begin
        shift_next     = hold_data;
        cnt_next       = '0;
        tran_byte_next = hold_data[WORD_B-1 -: BYTE_B];
        tran_dv_next   = 1'b1;
        state_next     = WAIT_REQ;
      end
      WAIT_REQ: begin
        // Deselect wins over a coincident byte request.
        if (cs_rise) begin
          abort_next     = 1'b1;
          tran_byte_next = IDLE_BYTE;
          state_next     = IDLE;
        end else if (spi_byte_req) begin
          if (byte_cnt == LAST) begin
            done_next      = 1'b1;
            tran_byte_next = IDLE_BYTE;
            state_next     = IDLE;
          end else begin
            cnt_next       = byte_cnt + CNT_W'(1);
            shift_next     = shift_reg << BYTE_B;
            tran_byte_next = shift_reg[WORD_B-1-BYTE_B -: BYTE_B];
            tran_dv_next   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      byte_cnt    <= '0;
      tran_dv     <= 1'b0;
      tran_byte   <= IDLE_BYTE;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      cs_q        <= 1'b1;
    end else begin
      state       <= state_next;
      shift_reg   <= shift_next;
      byte_cnt    <= cnt_next;
      tran_dv     <= tran_dv_next;
      tran_byte   <= tran_byte_next;
      frame_done  <= done_next;
      frame_abort <= abort_next;
      cs_q        <= spi_cs_n;
    end
  end

endmodule

// File: tb/tb_spi_tx_framer.sv
// Directed bench for spi_tx_framer: expected bytes are queued when words are
// offered and popped whenever the framer strobes tran_dv.
module tb_spi_tx_framer;

  logic        clk;
  logic        rst;
  logic        tx_dv;
  logic [63:0] tx_64bit;
  logic        tx_ready;
  logic        spi_byte_req;
  logic        spi_cs_n;
  logic        tran_dv;
  logic [7:0]  tran_byte;
  logic        frame_done;
  logic        frame_abort;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int tran_cnt = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int saved_aborts;
  logic [7:0] exp_q[$];
  logic [63:0] w5, w7;

  spi_tx_framer dut (
    .CLK100MHZ    (clk),
    .ck_rst       (rst),
    .tx_dv        (tx_dv),
    .tx_64bit     (tx_64bit),
    .tx_ready     (tx_ready),
    .spi_byte_req (spi_byte_req),
    .spi_cs_n     (spi_cs_n),
    .tran_dv      (tran_dv),
    .tran_byte    (tran_byte),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "bench did not complete");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] w);
    for (int k = 0; k < 8; k++) exp_q.push_back(w[63-8*k -: 8]);
  endtask

  // Advance one cycle, then sample and score any byte strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1)  done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
    if (tran_dv === 1'b1) begin
      tran_cnt++;
      if (exp_q.size() > 0) check("tran_byte", tran_byte, exp_q.pop_front());
      else                  check("tran_dv_unexpected", tran_dv, 1'b0);
    end
  endtask

  task automatic send_word(input logic [63:0] w, input bit expect_sent);
    tx_dv    = 1'b1;
    tx_64bit = w;
    if (expect_sent) push_word(w);
    tick();
    tx_dv = 1'b0;
  endtask

  task automatic req_pulse();
    repeat (9) tick();
    spi_byte_req = 1'b1;
    tick();
    spi_byte_req = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    tx_dv        = 1'b0;
    tx_64bit     = '0;
    spi_byte_req = 1'b0;
    spi_cs_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_tran_dv", tran_dv, 1'b0);
    check("rst_tran_byte", tran_byte, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_abort", frame_abort, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    tick();

    // Byte request with nothing queued.
    spi_byte_req = 1'b1;
    tick();
    spi_byte_req = 1'b0;
    check("idle_req_tran_dv", tran_dv, 1'b0);
    check("idle_req_tran_byte", tran_byte, 8'h00);
    tick();
    check("idle_req_tx_ready", tx_ready, 1'b1);

    // Single frame with latency checks.
    send_word(64'h0123_4567_89AB_CDEF, 1'b1);
    check("single_hold_full", tx_ready, 1'b0);
    tick();
    check("single_load_no_dv", tran_dv, 1'b0);
    tick();
    check("single_byte0_dv", tran_dv, 1'b1);
    check("single_drained", tx_ready, 1'b1);
    for (int i = 1; i < 8; i++) req_pulse();
    check("single_not_done_early", frame_done, 1'b0);
    req_pulse();
    check("single_done", frame_done, 1'b1);
    check("single_idle_byte", tran_byte, 8'h00);
    check("single_done_no_dv", tran_dv, 1'b0);
    tick();
    check("single_done_pulse", frame_done, 1'b0);
    check("single_q_empty", exp_q.size(), 0);

    // Overflow: B lands in the drain cycle of A, C arrives while B is held.
    send_word(64'hA0A1_A2A3_A4A5_A6A7, 1'b1);
    tick();
    send_word(64'hB0B1_B2B3_B4B5_B6B7, 1'b1);
    check("ovf_b_held", tx_ready, 1'b0);
    check("ovf_not_yet", overflow, 1'b0);
    send_word(64'hC0C1_C2C3_C4C5_C6C7, 1'b0);
    check("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) req_pulse();
    check("ovf_a_done", frame_done, 1'b1);
    tick();
    check("b2b_gap_no_dv", tran_dv, 1'b0);
    tick();
    check("b2b_b_byte0_dv", tran_dv, 1'b1);
    for (int i = 0; i < 8; i++) req_pulse();
    check("ovf_b_done", frame_done, 1'b1);
    check("ovf_sticky", overflow, 1'b1);

    // Abort after three bytes with another word pending.
    send_word(64'hFFFF_0000_FFFF_0000, 1'b1);
    tick();
    tick();
    send_word(64'h1122_3344_5566_7788, 1'b1);
    req_pulse();
    req_pulse();
    for (int i = 0; i < 5; i++) exp_q.delete(0);
    spi_cs_n = 1'b1;
    tick();
    check("abort_pulse", frame_abort, 1'b1);
    check("abort_idle_byte", tran_byte, 8'h00);
    check("abort_no_dv", tran_dv, 1'b0);
    check("abort_pending_kept", tx_ready, 1'b0);
    spi_cs_n = 1'b0;
    tick();
    check("abort_single_pulse", frame_abort, 1'b0);
    tick();
    check("abort_next_byte0_dv", tran_dv, 1'b1);
    for (int i = 0; i < 8; i++) req_pulse();
    check("abort_next_done", frame_done, 1'b1);

    // Request and deselect together on the last byte.
    send_word(64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 7; i++) req_pulse();
    repeat (9) tick();
    spi_byte_req = 1'b1;
    spi_cs_n     = 1'b1;
    tick();
    spi_byte_req = 1'b0;
    check("simul_abort", frame_abort, 1'b1);
    check("simul_no_done", frame_done, 1'b0);
    check("simul_idle_byte", tran_byte, 8'h00);
    spi_cs_n = 1'b0;
    tick();
    check("simul_q_empty", exp_q.size(), 0);

    // Reset after byte 3 with a word still pending.
    w5 = {$urandom(), $urandom()};
    send_word(w5, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) req_pulse();
    send_word(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_ready", tx_ready, 1'b1);
    check("mid_rst_tran_dv", tran_dv, 1'b0);
    check("mid_rst_tran_byte", tran_byte, 8'h00);
    check("mid_rst_frame_done", frame_done, 1'b0);
    check("mid_rst_frame_abort", frame_abort, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    saved_aborts = abort_cnt;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_no_abort", abort_cnt, saved_aborts);
    check("post_rst_empty", tx_ready, 1'b1);

    // Recovery frame.
    w7 = {$urandom(), $urandom()};
    send_word(w7, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 8; i++) req_pulse();
    check("recover_done", frame_done, 1'b1);
    tick();

    check("total_bytes", tran_cnt, 55);
    check("total_done", done_cnt, 5);
    check("total_abort", abort_cnt, 2);
    check("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
